// File: rtl/rv32_pkg.sv
// Shared types and defaults for the RV32 instruction-memory slice.
package rv32_pkg;

  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned IMEM_ADDR_W = 13;
  localparam int unsigned IMEM_DEPTH  = 1 << IMEM_ADDR_W;

  typedef logic [IMEM_ADDR_W-1:0]   rv32_imem_addr_t;
  typedef logic [IMEM_DATA_W/8-1:0] rv32_imem_be_t;

  // IDLE serves the loader and fetch ports; CLEAR owns the array's write port.
  typedef enum logic {
    IMEM_IDLE  = 1'b0,
    IMEM_CLEAR = 1'b1
  } imem_state_e;

endpackage

// File: rtl/rv32_imem_rd_port.sv
// One read port: write-first byte merge, valid gating and a 1- or 2-stage
// registered output pipeline.
module rv32_imem_rd_port
  import rv32_pkg::*;
#(
  parameter int unsigned DATA_W     = IMEM_DATA_W,
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              rd_allow,
  input  logic              wr_fire,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] merged;
  logic              take;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  assign take = rd_en & rd_allow;

  // Enabled bytes of a same-address write in this cycle override the array word.
  always_comb begin
    merged = arr_data;
    if (wr_fire && (wr_addr == rd_addr)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  // First output stage: data only moves on an accepted read, so it holds otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= take;
      if (take) s1_data <= merged;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Extra stage drains regardless of the clear engine.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
  end else begin : g_lat1
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
  end

endmodule

// File: rtl/rv32_imem_mp.sv
// Multi-port instruction memory: NUM_RD read ports, one byte-enabled loader
// write port, and a zero-fill engine that owns the array while clearing.
module rv32_imem_mp
  import rv32_pkg::*;
#(
  parameter int unsigned DATA_W         = IMEM_DATA_W,
  parameter int unsigned ADDR_W         = IMEM_ADDR_W,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     init_start,
  output logic                     init_busy,
  output logic                     init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam imem_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? IMEM_CLEAR : IMEM_IDLE;

  imem_state_e       state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic              done_nxt;
  logic              wr_fire;

  logic [DATA_W-1:0] mem [DEPTH];

  assign wr_ready  = (state == IMEM_IDLE);
  assign init_busy = (state == IMEM_CLEAR);
  assign wr_fire   = wr_valid & wr_ready;

  // Clear FSM state, counter and done pulse.
  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      init_done <= done_nxt;
    end
  end

  // Next-state logic: sweep every word once, then return to IDLE and pulse done.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed branch would otherwise infer a latch.
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    done_nxt    = 1'b0;
    unique case (state)
      IMEM_IDLE: begin
        if (init_start) state_nxt = IMEM_CLEAR;
      end
      IMEM_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state_nxt = IMEM_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IMEM_IDLE;
    endcase
  end

  // Single array write port: clear engine while clearing, loader otherwise.
  // NOTE: the array is deliberately not reset; a reset term would stop it mapping onto block RAM, and the clear engine provides known contents.
  always_ff @(posedge clock) begin
    if (state == IMEM_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] arr_q;

    assign addr_i = rd_addr[i*ADDR_W +: ADDR_W];
    assign arr_q  = mem[addr_i];

    rv32_imem_rd_port #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .RD_LATENCY (RD_LATENCY)
    ) u_port (
      .clock    (clock),
      .rst_n    (rst_n),
      .rd_en    (rd_en[i]),
      .rd_addr  (addr_i),
      .arr_data (arr_q),
      .rd_allow (wr_ready),
      .wr_fire  (wr_fire),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_be    (wr_be),
      .rd_data  (rd_data[i*DATA_W +: DATA_W]),
      .rd_valid (rd_valid[i])
    );
  end

endmodule

// File: tb/tb_rv32_imem_mp.sv
// Scoreboard bench: two 4-port instances (latency 1 and 2) share stimulus;
// a small third instance covers CLEAR_ON_RESET=0 reset values.
module tb_rv32_imem_mp;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct packed {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic              rst_n;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [3:0]        wr_be;
  logic              init_start;

  logic [NR*DW-1:0]  rdd_a, rdd_b;
  logic [NR-1:0]     rdv_a, rdv_b;
  logic              wrr_a, wrr_b, busy_a, busy_b, done_a, done_b;
  logic [DW-1:0]     rdd_c;
  logic              rdv_c, wrr_c, busy_c, done_c;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb [2*NR][$];

  rv32_imem_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
    .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(rdv_a),
    .wr_valid(wr_valid), .wr_ready(wrr_a), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .init_start(init_start), .init_busy(busy_a), .init_done(done_a));

  rv32_imem_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
    .clock(clock), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_valid(rdv_b),
    .wr_valid(wr_valid), .wr_ready(wrr_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .init_start(init_start), .init_busy(busy_b), .init_done(done_b));

  rv32_imem_mp #(.DATA_W(DW), .ADDR_W(4), .NUM_RD(1), .RD_LATENCY(1), .CLEAR_ON_RESET(0)) u_c (
    .clock(clock), .rst_n(rst_n), .rd_en(1'b0), .rd_addr(4'h0), .rd_data(rdd_c), .rd_valid(rdv_c),
    .wr_valid(1'b0), .wr_ready(wrr_c), .wr_addr(4'h0), .wr_data(32'h0), .wr_be(4'h0),
    .init_start(1'b0), .init_busy(busy_c), .init_done(done_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  // Monitor: every rd_valid must match the oldest expectation for that port, in the expected cycle.
  always @(negedge clock) begin : mon
    logic        v;
    logic [31:0] dat;
    exp_t        e;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NR; p++) begin
        v   = (d == 0) ? rdv_a[p] : rdv_b[p];
        dat = (d == 0) ? rdd_a[p*DW +: DW] : rdd_b[p*DW +: DW];
        if (v === 1'b1) begin
          if (sb[d*NR+p].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rd_valid dut=%0d port=%0d: got valid data %h, expected no valid (cycle %0d)",
                     d, p, dat, cyc);
          end else begin
            e = sb[d*NR+p].pop_front();
            check($sformatf("rd_data dut%0d port%0d", d, p), dat, e.data);
            check($sformatf("rd_cycle dut%0d port%0d", d, p), cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    rd_en      = '0;
    wr_valid   = 1'b0;
    wr_be      = '0;
    init_start = 1'b0;
  endtask

  task automatic expect_rd(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    rd_en[p]            = 1'b1;
    rd_addr[p*AW +: AW] = a;
    sb[p].push_back(exp_t'{data: d, cyc: cyc + 1});
    sb[NR+p].push_back(exp_t'{data: d, cyc: cyc + 2});
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
  endtask

  // Samples busy/done every cycle over a bounded window starting in the first CLEAR cycle.
  task automatic measure_clear(input int poke_at, output int busy_n, output int done_n, output int bad_n);
    busy_n = 0;
    done_n = 0;
    bad_n  = 0;
    for (int i = 0; i < 8300; i++) begin
      if (busy_a === 1'b1) busy_n++;
      if (done_a === 1'b1) done_n++;
      if (wrr_a === busy_a || busy_a !== busy_b || done_a !== done_b || wrr_b === busy_b) bad_n++;
      if (i == poke_at) init_start = 1'b1;
      if (i == 10) rd_en = '1;
      tick();
    end
  endtask

  task automatic check_clear(input string tag, input int poke_at);
    int busy_n, done_n, bad_n;
    measure_clear(poke_at, busy_n, done_n, bad_n);
    check({tag, " busy_cycles"}, busy_n, 8192);
    check({tag, " done_pulses"}, done_n, 1);
    check({tag, " ready_busy_consistency"}, bad_n, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy_a"}, busy_a, 1'b1);
    check({tag, " busy_b"}, busy_b, 1'b1);
    check({tag, " wr_ready_a"}, wrr_a, 1'b0);
    check({tag, " done_a"}, done_a, 1'b0);
    check({tag, " rd_valid_a"}, rdv_a, '0);
    check({tag, " rd_valid_b"}, rdv_b, '0);
    for (int p = 0; p < NR; p++) begin
      check($sformatf("%s rd_data_a p%0d", tag, p), rdd_a[p*DW +: DW], 32'h0);
      check($sformatf("%s rd_data_b p%0d", tag, p), rdd_b[p*DW +: DW], 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    rd_en      = '0;
    rd_addr    = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_be      = '0;
    init_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset values.
    check_reset_outputs("reset");
    check("reset busy_c", busy_c, 1'b0);
    check("reset wr_ready_c", wrr_c, 1'b1);
    check("reset done_c", done_c, 1'b0);
    check("reset rd_valid_c", rdv_c, 1'b0);
    check("reset rd_data_c", rdd_c, 32'h0);

    // Power-on clear: 8192 busy cycles, one done pulse.
    rst_n = 1'b1;
    check_clear("por_clear", -1);
    check("after_clear wr_ready", wrr_a, 1'b1);

    // Cleared contents read as zero, including the top word.
    expect_rd(0, 13'h010, 32'h0);
    expect_rd(1, 13'h1FFF, 32'h0);
    expect_rd(2, 13'h020, 32'h0);
    expect_rd(3, 13'h000, 32'h0);
    tick();

    // Full write then single-byte write.
    wr(13'h010, 32'hDEADBEEF, 4'hF);
    tick();
    wr(13'h010, 32'h000000AA, 4'h1);
    tick();
    expect_rd(0, 13'h010, 32'hDEADBEAA);
    tick();
    repeat (3) tick();
    check("hold rd_data_a p0", rdd_a[31:0], 32'hDEADBEAA);
    check("hold rd_data_b p0", rdd_b[31:0], 32'hDEADBEAA);

    // All-zero byte enable: accepted, contents unchanged.
    wr(13'h010, 32'h0, 4'h0);
    check("be0 wr_ready", wrr_a, 1'b1);
    tick();
    expect_rd(1, 13'h010, 32'hDEADBEAA);
    tick();

    // Read-during-write, write-first byte merge on two ports.
    wr(13'h020, 32'h12345678, 4'b1100);
    expect_rd(0, 13'h020, 32'h12340000);
    expect_rd(1, 13'h020, 32'h12340000);
    tick();
    expect_rd(2, 13'h020, 32'h12340000);
    tick();
    // A write after the sample edge must not alter the in-flight read.
    expect_rd(0, 13'h020, 32'h12340000);
    tick();
    wr(13'h020, 32'hFFFFFFFF, 4'hF);
    tick();
    expect_rd(0, 13'h020, 32'hFFFFFFFF);
    tick();

    // Load pattern words 0..15.
    for (int i = 0; i < 16; i++) begin
      wr(AW'(i), pat(i), 4'hF);
      tick();
    end

    // Four ports, four different addresses, then all on one address.
    for (int p = 0; p < NR; p++) expect_rd(p, AW'(p), pat(p));
    tick();
    for (int p = 0; p < NR; p++) expect_rd(p, 13'h005, pat(5));
    tick();

    // Back-to-back reads; the last one coincides with init_start and must still emerge.
    for (int i = 0; i < 16; i++) begin
      expect_rd(0, AW'(i), pat(i));
      if (i == 15) init_start = 1'b1;
      tick();
    end
    // Clear via init_start: a mid-clear init_start is ignored, reads inside are dropped.
    check_clear("cmd_clear", 50);

    // Cleared contents after commanded clear.
    expect_rd(3, 13'h003, 32'h0);
    tick();
    repeat (3) tick();

    // Reset in the middle of a clear: everything restarts.
    init_start = 1'b1;
    tick();
    repeat (100) tick();
    check("pre_reset busy_a", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_clear_reset");
    tick();
    rst_n = 1'b1;
    check_clear("restart_clear", -1);

    expect_rd(0, 13'h010, 32'h0);
    tick();
    repeat (4) tick();

    for (int q = 0; q < 2*NR; q++) check($sformatf("pending_reads sb%0d", q), sb[q].size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
